// File: rtl/hazard_stall_ctrl.sv
// ID-stage sequencer: load-use hazard detection, branch flush and stall sequencing
// with saturating stall/flush performance counters.
module hazard_stall_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_ins,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC - 1) : 1;
    localparam logic [CW-1:0] STALL_LOAD = (STALL_CYCLES > 1) ? CW'(STALL_CYCLES - 2) : '0;
    localparam logic [CW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          stall_inc, flush_inc;

    logic [4:0] rs1, rs2;
    logic [6:0] opcode;
    logic       uses_rs2, hazard;
    logic       unused_bits;

    assign opcode      = id_ins[6:0];
    assign rs1         = id_ins[19:15];
    assign rs2         = id_ins[24:20];
    assign unused_bits = ^{id_ins[31:25], id_ins[14:7]};
    assign uses_rs2    = (opcode == 7'b0110011) || (opcode == 7'b0100011) ||
                         (opcode == 7'b1100011);
    assign hazard      = idex_mem_read && (idex_rd != 5'd0) &&
                         ((idex_rd == rs1) || (uses_rs2 && (idex_rd == rs2)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_nx    = state;
        cnt_nx      = cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ext_stall) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            // A taken branch wins in every state; FLUSH is re-entered with a fresh count.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_nx    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            cnt_nx      = FLUSH_LOAD;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        state_nx    = (STALL_CYCLES > 1) ? STALL : RUN;
                        cnt_nx      = STALL_LOAD;
                    end
                end
                STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    if (cnt == '0) state_nx = RUN;
                    else           cnt_nx   = cnt - CW'(1);
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt == '0) state_nx = RUN;
                    else           cnt_nx   = cnt - CW'(1);
                end
                default: state_nx = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default, 3-cycle-stall and 2-bit-counter instances.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_ins;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic        branch_taken;
    logic        ext_stall;

    logic        a_pcw, a_ifw, a_fl, a_bub, a_hold;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_pcw, b_ifw, b_fl, b_bub, b_hold;
    logic [31:0] b_scnt, b_fcnt;
    logic        s_pcw, s_ifw, s_fl, s_bub, s_hold;
    logic [1:0]  s_scnt, s_fcnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset), .id_ins(id_ins), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_write(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_fl), .idex_bubble(a_bub),
        .pipe_hold(a_hold), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    hazard_stall_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(32)) dut3 (
        .clk(clk), .reset(reset), .id_ins(id_ins), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_write(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_fl), .idex_bubble(b_bub),
        .pipe_hold(b_hold), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    hazard_stall_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_ins(id_ins), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_write(s_pcw), .ifid_write(s_ifw), .ifid_flush(s_fl), .idex_bubble(s_bub),
        .pipe_hold(s_hold), .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    localparam logic [31:0] ADD_X7 = 32'h006283B3;
    localparam logic [31:0] SD_X5  = 32'h00513423;
    localparam logic [31:0] LD_X9  = 32'h0051B483;
    localparam logic [31:0] BEQ_15 = 32'h00508063;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ins        = 32'h00000013;
        idex_mem_read = 1'b0;
        idex_rd       = 5'd0;
        branch_taken  = 1'b0;
        ext_stall     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #2;
        checks++;
        if ({a_pcw, a_ifw, a_fl, a_bub, a_hold} !== 5'b00110) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00110", {a_pcw, a_ifw, a_fl, a_bub, a_hold});
        end
        tick();
        tick();
        reset = 1'b0;
        #2;
        checks++;
        if ({a_pcw, a_ifw, a_fl, a_bub, a_hold} !== 5'b11000) begin
            failures++;
            $display("FAIL run_after_reset: got %b want 11000", {a_pcw, a_ifw, a_fl, a_bub, a_hold});
        end
        checks++;
        if (a_scnt !== 32'd0 || a_fcnt !== 32'd0) begin
            failures++;
            $display("FAIL counters_after_reset: got %0d/%0d want 0/0", a_scnt, a_fcnt);
        end
    endtask

    task automatic test_load_use_rtype();
        do_reset();
        id_ins = ADD_X7; idex_mem_read = 1'b1; idex_rd = 5'd5;
        #1;
        checks++;
        if ({a_pcw, a_ifw, a_bub, a_fl} !== 4'b0010) begin
            failures++;
            $display("FAIL rs1_hazard: got %b want 0010", {a_pcw, a_ifw, a_bub, a_fl});
        end
        tick();
        idex_mem_read = 1'b0;
        #1;
        checks++;
        if (a_scnt !== 32'd1 || a_pcw !== 1'b1) begin
            failures++;
            $display("FAIL single_stall_done: got cnt=%0d pcw=%b want 1/1", a_scnt, a_pcw);
        end
        idex_mem_read = 1'b1; idex_rd = 5'd6;
        #1;
        checks++;
        if (a_pcw !== 1'b0) begin
            failures++;
            $display("FAIL rs2_hazard: got pc_write=%b want 0", a_pcw);
        end
        tick();
        idex_rd = 5'd0;
        #1;
        checks++;
        if (a_pcw !== 1'b1 || a_bub !== 1'b0) begin
            failures++;
            $display("FAIL rd_zero_no_stall: got pcw=%b bub=%b want 1/0", a_pcw, a_bub);
        end
        idex_rd = 5'd5; idex_mem_read = 1'b0;
        #1;
        checks++;
        if (a_pcw !== 1'b1) begin
            failures++;
            $display("FAIL no_load_no_stall: got pc_write=%b want 1", a_pcw);
        end
        tick();
        checks++;
        if (a_scnt !== 32'd2) begin
            failures++;
            $display("FAIL stall_cnt_rtype: got %0d want 2", a_scnt);
        end
    endtask

    task automatic test_rs2_decode();
        do_reset();
        id_ins = SD_X5; idex_mem_read = 1'b1; idex_rd = 5'd5;
        #1;
        checks++;
        if (a_pcw !== 1'b0 || a_bub !== 1'b1) begin
            failures++;
            $display("FAIL store_rs2_hazard: got pcw=%b bub=%b want 0/1", a_pcw, a_bub);
        end
        tick();
        id_ins = LD_X9;
        #1;
        checks++;
        if (a_pcw !== 1'b1 || a_bub !== 1'b0) begin
            failures++;
            $display("FAIL itype_rs2_ignored: got pcw=%b bub=%b want 1/0", a_pcw, a_bub);
        end
        tick();
        id_ins = BEQ_15;
        #1;
        checks++;
        if (a_pcw !== 1'b0) begin
            failures++;
            $display("FAIL branch_rs2_hazard: got pc_write=%b want 0", a_pcw);
        end
        tick();
        checks++;
        if (a_scnt !== 32'd2) begin
            failures++;
            $display("FAIL stall_cnt_decode: got %0d want 2", a_scnt);
        end
    endtask

    task automatic test_multi_stall();
        int bubbles = 0;
        do_reset();
        id_ins = ADD_X7; idex_mem_read = 1'b1; idex_rd = 5'd5;
        #1;
        if (b_bub === 1'b1 && b_pcw === 1'b0) bubbles++;
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            if (b_bub === 1'b1 && b_pcw === 1'b0) bubbles++;
            tick();
        end
        checks++;
        if (bubbles !== 3) begin
            failures++;
            $display("FAIL stall3_bubbles: got %0d want 3", bubbles);
        end
        checks++;
        if (b_scnt !== 32'd3) begin
            failures++;
            $display("FAIL stall3_cnt: got %0d want 3", b_scnt);
        end
        checks++;
        if (b_pcw !== 1'b1 || b_ifw !== 1'b1) begin
            failures++;
            $display("FAIL stall3_back_to_run: got pcw=%b ifw=%b want 1/1", b_pcw, b_ifw);
        end
    endtask

    task automatic test_branch_in_stall();
        int flushes = 0;
        do_reset();
        id_ins = ADD_X7; idex_mem_read = 1'b1; idex_rd = 5'd5;
        tick();
        clear_inputs();
        branch_taken = 1'b1;
        #1;
        checks++;
        if ({b_pcw, b_fl, b_bub} !== 3'b111) begin
            failures++;
            $display("FAIL branch_overrides_stall: got %b want 111", {b_pcw, b_fl, b_bub});
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            if (b_fl === 1'b1) flushes++;
            tick();
            branch_taken = 1'b0;
        end
        checks++;
        if (flushes !== 2) begin
            failures++;
            $display("FAIL stall_branch_flush_cycles: got %0d want 2", flushes);
        end
        checks++;
        if (b_fcnt !== 32'd1 || b_scnt !== 32'd1) begin
            failures++;
            $display("FAIL stall_branch_counts: got f=%0d s=%0d want 1/1", b_fcnt, b_scnt);
        end
    endtask

    task automatic test_ext_stall_in_flush();
        do_reset();
        branch_taken = 1'b1;
        #1;
        checks++;
        if ({a_pcw, a_fl, a_bub} !== 3'b111) begin
            failures++;
            $display("FAIL branch_flush_outputs: got %b want 111", {a_pcw, a_fl, a_bub});
        end
        tick();
        branch_taken = 1'b0;
        ext_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({a_hold, a_pcw, a_ifw, a_fl, a_bub} !== 5'b10000) begin
                failures++;
                $display("FAIL ext_hold_cycle%0d: got %b want 10000", i,
                         {a_hold, a_pcw, a_ifw, a_fl, a_bub});
            end
            tick();
        end
        ext_stall = 1'b0;
        #1;
        checks++;
        if ({a_hold, a_fl, a_bub, a_pcw} !== 4'b0111) begin
            failures++;
            $display("FAIL flush_resumes: got %b want 0111", {a_hold, a_fl, a_bub, a_pcw});
        end
        tick();
        checks++;
        if (a_fl !== 1'b0 || a_fcnt !== 32'd1) begin
            failures++;
            $display("FAIL flush_done: got fl=%b fcnt=%0d want 0/1", a_fl, a_fcnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        branch_taken = 1'b1;
        tick();
        tick();
        branch_taken = 1'b0;
        id_ins = ADD_X7; idex_mem_read = 1'b1; idex_rd = 5'd5;
        #1;
        checks++;
        if ({a_fl, a_pcw} !== 2'b11) begin
            failures++;
            $display("FAIL reload_flush_hazard_ignored: got %b want 11", {a_fl, a_pcw});
        end
        tick();
        #1;
        checks++;
        if ({a_fl, a_pcw, a_bub} !== 3'b001) begin
            failures++;
            $display("FAIL hazard_after_flush: got %b want 001", {a_fl, a_pcw, a_bub});
        end
        tick();
        checks++;
        if (a_fcnt !== 32'd2 || a_scnt !== 32'd1) begin
            failures++;
            $display("FAIL back_to_back_counts: got f=%0d s=%0d want 2/1", a_fcnt, a_scnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        id_ins = ADD_X7; idex_mem_read = 1'b1; idex_rd = 5'd5;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (s_scnt !== 2'd3) begin
            failures++;
            $display("FAIL sat_reach_max: got %0d want 3", s_scnt);
        end
        tick();
        tick();
        checks++;
        if (s_scnt !== 2'd3) begin
            failures++;
            $display("FAIL sat_no_wrap: got %0d want 3", s_scnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (s_pcw !== 1'b0 || s_fl !== 1'b1) begin
            failures++;
            $display("FAIL reset_priority: got pcw=%b fl=%b want 0/1", s_pcw, s_fl);
        end
        tick();
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use_rtype();
        test_rs2_decode();
        test_multi_stall();
        test_branch_in_stall();
        test_ext_stall_in_flush();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
